// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and access sequencer for a single-ported
// MEM_BYTES-byte data memory. Requester A is the processor load/store path,
// requester B the loader/debug port. Each accepted request is sequenced as
// one 64-bit little-endian access (IDLE -> ACCESS -> RESP). Out-of-range
// addresses (addr > MEM_BYTES-8) are flagged and never reach the memory.
//
// Optional feature macro: DMEM_ARB_RR_EN
//   defined   : round-robin arbitration on conflict (last owner loses)
//   undefined : fixed priority, A beats B
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   a_*/b_* req,we,addr,wdata  request side (held stable until gnt)
//   a_*/b_* gnt           one-cycle grant pulse (ACCESS cycle)
//   a_*/b_* rsp_valid,rdata,err  one-cycle registered response (RESP cycle)
//   mem_addr, mem_wdata, mem_write, mem_read  to memory
//   mem_rdata             combinational read data from memory
module dmem_arbiter #(
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [63:0] a_addr,
  input  logic [63:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rsp_valid,
  output logic [63:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [63:0] b_addr,
  input  logic [63:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rsp_valid,
  output logic [63:0] b_rdata,
  output logic        b_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  state_t      state;
  logic        owner_b;
  logic        err_q;
  logic        rd_q;
  logic        wr_q;

  logic        pick_b;
  logic        pick_we;
  logic [63:0] pick_addr;
  logic [63:0] pick_wdata;
  logic        pick_err;

`ifdef DMEM_ARB_RR_EN
  logic        last_b;
`endif

  always_comb begin
`ifdef DMEM_ARB_RR_EN
    // On conflict the requester that did not own the last access wins.
    pick_b = b_req & (~a_req | ~last_b);
`else
    pick_b = b_req & ~a_req;
`endif
    pick_we    = pick_b ? b_we    : a_we;
    pick_addr  = pick_b ? b_addr  : a_addr;
    pick_wdata = pick_b ? b_wdata : a_wdata;
    pick_err   = pick_addr > MAX_ADDR;
  end

  // Reset gates the write strobe combinationally so a reset landing in the
  // ACCESS cycle suppresses the commit at that same edge.
  assign mem_write = wr_q & ~reset;
  assign mem_read  = rd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner_b     <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      a_gnt       <= 1'b0;
      b_gnt       <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      a_err       <= 1'b0;
      b_err       <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifdef DMEM_ARB_RR_EN
      last_b      <= 1'b1;
`endif
    end else begin
      // Pulse outputs default low; the state case raises them for one cycle.
      a_gnt       <= 1'b0;
      b_gnt       <= 1'b0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
      a_err       <= 1'b0;
      b_err       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      case (state)
        IDLE: begin
          if (a_req | b_req) begin
            state     <= ACCESS;
            owner_b   <= pick_b;
            mem_addr  <= pick_addr;
            mem_wdata <= pick_wdata;
            err_q     <= pick_err;
            rd_q      <= ~pick_we & ~pick_err;
            wr_q      <= pick_we & ~pick_err;
            a_gnt     <= ~pick_b;
            b_gnt     <= pick_b;
`ifdef DMEM_ARB_RR_EN
            last_b    <= pick_b;
`endif
          end
        end
        ACCESS: begin
          state <= RESP;
          if (owner_b) begin
            b_rsp_valid <= 1'b1;
            b_rdata     <= rd_q ? mem_rdata : '0;
            b_err       <= err_q;
          end else begin
            a_rsp_valid <= 1'b1;
            a_rdata     <= rd_q ? mem_rdata : '0;
            a_err       <= err_q;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a byte-array memory serves the DUT,
// while a separate reference byte array models the intended memory contents
// and response values transaction by transaction.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [63:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_gnt, a_rsp_valid, a_err, b_gnt, b_rsp_valid, b_err;
  logic [63:0] a_rdata, b_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;

  logic [7:0]  mem     [64] = '{default: 8'h00};
  logic [7:0]  ref_mem [64] = '{default: 8'h00};

  int vectors     = 0;
  int miscompares = 0;
  int writes_seen = 0;
  int violations  = 0;
  bit last_owner_b = 1'b1;

  dmem_arbiter #(.MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached memory: combinational read, write at the clock edge.
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem[6'(mem_addr[5:0] + 6'(i))];
  end

  always @(posedge clk) begin
    if (mem_write) begin
      writes_seen++;
      for (int i = 0; i < 8; i++) mem[6'(mem_addr[5:0] + 6'(i))] <= mem_wdata[8*i +: 8];
    end
  end

  // Protocol invariants sampled mid-cycle.
  always @(negedge clk) begin
    if ((a_gnt && b_gnt) || (a_rsp_valid && b_rsp_valid) || (mem_write && mem_read) ||
        (!a_rsp_valid && (a_err || a_rdata != 0)) || (!b_rsp_valid && (b_err || b_rdata != 0)))
      violations++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_read(input logic [63:0] addr);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_mem[int'(addr[5:0]) + i];
    return r;
  endfunction

  task automatic ref_apply(input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                           output logic [63:0] rdata, output logic err);
    err   = (addr > 64'd56);
    rdata = '0;
    if (!err) begin
      if (we) for (int i = 0; i < 8; i++) ref_mem[int'(addr[5:0]) + i] = wdata[8*i +: 8];
      else rdata = ref_read(addr);
    end
  endtask

  function automatic bit model_pick_b();
`ifdef DMEM_ARB_RR_EN
    return !last_owner_b;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 64'($urandom_range(0, 7) * 8);
      1:       return 64'($urandom_range(0, 56));
      2:       return 64'($urandom_range(57, 63));
      default: return {$urandom | 32'h1, $urandom};
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit req, input bit we,
                       input logic [63:0] addr, input logic [63:0] wdata);
    if (p == 0) begin a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; end
    else        begin b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; end
  endtask

  function automatic bit gnt_of(input int p);          return p ? b_gnt : a_gnt; endfunction
  function automatic bit rsp_of(input int p);          return p ? b_rsp_valid : a_rsp_valid; endfunction
  function automatic logic [63:0] rdata_of(input int p); return p ? b_rdata : a_rdata; endfunction
  function automatic logic err_of(input int p);        return p ? b_err : a_err; endfunction

  // Single-port access starting in IDLE; cycle numbers count from req assertion.
  task automatic access(input int p, input bit we, input logic [63:0] addr, input logic [63:0] wdata,
                        output int gnt_cyc, output int rsp_cyc, output logic [63:0] rdata, output logic err);
    gnt_cyc = -1; rsp_cyc = -1; rdata = 'x; err = 1'bx;
    drive(p, 1'b1, we, addr, wdata);
    for (int c = 1; c <= 10 && rsp_cyc < 0; c++) begin
      tick();
      if (gnt_of(p)) begin gnt_cyc = c; drive(p, 1'b0, we, addr, wdata); end
      if (rsp_of(p)) begin rsp_cyc = c; rdata = rdata_of(p); err = err_of(p); end
    end
    drive(p, 1'b0, we, addr, wdata);
    tick();
    last_owner_b = (p != 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    reset = 1'b0;
    last_owner_b = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vectors++;
    if ({a_gnt, b_gnt, a_rsp_valid, b_rsp_valid, a_err, b_err, mem_write, mem_read} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 00000000",
               {a_gnt, b_gnt, a_rsp_valid, b_rsp_valid, a_err, b_err, mem_write, mem_read});
    end
    vectors++;
    if ({a_rdata, b_rdata, mem_addr, mem_wdata} !== 256'h0) begin
      miscompares++;
      $display("FAIL reset_data: a_rdata=%h b_rdata=%h mem_addr=%h mem_wdata=%h required all 0",
               a_rdata, b_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_write_read();
    int g, r; logic [63:0] d, ed; logic e, ee;
    ref_apply(1'b1, 64'd8, 64'h1122334455667788, ed, ee);
    access(0, 1'b1, 64'd8, 64'h1122334455667788, g, r, d, e);
    vectors++;
    if (g !== 1 || r !== 2) begin miscompares++; $display("FAIL wr_timing: gnt=%0d rsp=%0d required 1 2", g, r); end
    vectors++;
    if (mem[8] !== 8'h88) begin miscompares++; $display("FAIL wr_byte8: got %h required 88", mem[8]); end
    vectors++;
    if (d !== 64'h0 || e !== 1'b0) begin miscompares++; $display("FAIL wr_rsp: rdata=%h err=%b required 0 0", d, e); end
    ref_apply(1'b0, 64'd8, '0, ed, ee);
    access(0, 1'b0, 64'd8, '0, g, r, d, e);
    vectors++;
    if (d !== 64'h1122334455667788 || e !== 1'b0 || ed !== 64'h1122334455667788) begin
      miscompares++; $display("FAIL rd_back: rdata=%h err=%b required 1122334455667788 0", d, e);
    end
  endtask

  task automatic test_range();
    int g, r, w0; logic [63:0] d, ed; logic e, ee; int bad;
    w0 = writes_seen;
    ref_apply(1'b1, 64'd57, 64'hDEADBEEFCAFEF00D, ed, ee);
    access(1, 1'b1, 64'd57, 64'hDEADBEEFCAFEF00D, g, r, d, e);
    vectors++;
    if (e !== 1'b1 || d !== 64'h0) begin miscompares++; $display("FAIL range57: err=%b rdata=%h required 1 0", e, d); end
    vectors++;
    if (writes_seen !== w0) begin miscompares++; $display("FAIL range57_write: writes=%0d required %0d", writes_seen, w0); end
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL range57_mem: %0d bytes differ, required 0", bad); end
    ref_apply(1'b1, 64'd56, 64'h0102030405060708, ed, ee);
    access(1, 1'b1, 64'd56, 64'h0102030405060708, g, r, d, e);
    vectors++;
    if (e !== 1'b0 || g !== 1 || r !== 2 || mem[56] !== 8'h08) begin
      miscompares++; $display("FAIL range56: err=%b gnt=%0d rsp=%0d byte56=%h required 0 1 2 08", e, g, r, mem[56]);
    end
    access(1, 1'b0, 64'h0000_0001_0000_0008, '0, g, r, d, e);
    vectors++;
    if (e !== 1'b1 || d !== 64'h0) begin miscompares++; $display("FAIL range_hi: err=%b rdata=%h required 1 0", e, d); end
    access(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, '0, g, r, d, e);
    vectors++;
    if (e !== 1'b1 || d !== 64'h0 || r !== 2) begin
      miscompares++; $display("FAIL range_max: err=%b rdata=%h rsp=%0d required 1 0 2", e, d, r);
    end
  endtask

  task automatic test_reset_during_write();
    int w0, rsps; logic [63:0] m0, exp_d;
    do_reset();
    w0 = writes_seen; rsps = 0;
    drive(0, 1'b1, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    vectors++;
    if (a_gnt !== 1'b1) begin miscompares++; $display("FAIL rst_acc_gnt: got %b required 1", a_gnt); end
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    #1;
    vectors++;
    if (mem_write !== 1'b0) begin miscompares++; $display("FAIL rst_acc_wr: mem_write=%b required 0", mem_write); end
    tick();
    reset = 1'b0;
    vectors++;
    if ({a_gnt, a_rsp_valid, a_err, mem_write, mem_read} !== 5'b0 || {a_rdata, mem_addr, mem_wdata} !== 192'h0) begin
      miscompares++; $display("FAIL rst_acc_clear: gnt=%b rsp=%b addr=%h wdata=%h required all 0",
                              a_gnt, a_rsp_valid, mem_addr, mem_wdata);
    end
    for (int c = 0; c < 4; c++) begin tick(); if (a_rsp_valid || b_rsp_valid) rsps++; end
    for (int i = 0; i < 8; i++) m0[8*i +: 8] = mem[i];
    vectors++;
    if (m0 !== 64'h0 || writes_seen !== w0 || rsps !== 0) begin
      miscompares++; $display("FAIL rst_acc_effect: mem0=%h writes=%0d rsps=%0d required 0 %0d 0", m0, writes_seen, w0, rsps);
    end
    last_owner_b = 1'b1;
    // Reset landing in RESP: the response of that cycle is still visible.
    exp_d = ref_read(64'd8);
    drive(0, 1'b1, 1'b0, 64'd8, '0);
    tick();
    drive(0, 1'b0, 1'b0, 64'd8, '0);
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (a_rsp_valid !== 1'b1 || a_rdata !== exp_d) begin
      miscompares++; $display("FAIL rst_resp: rsp=%b rdata=%h required 1 %h", a_rsp_valid, a_rdata, exp_d);
    end
    tick();
    reset = 1'b0;
    last_owner_b = 1'b1;
    vectors++;
    if (a_rsp_valid !== 1'b0 || a_rdata !== 64'h0 || mem_addr !== 64'h0) begin
      miscompares++; $display("FAIL rst_resp_clear: rsp=%b rdata=%h addr=%h required 0 0 0", a_rsp_valid, a_rdata, mem_addr);
    end
  endtask

  task automatic test_unaligned();
    int g, r; logic [63:0] d, ed; logic e, ee;
    ref_apply(1'b1, 64'd0, 64'h00000000000000AA, ed, ee);
    access(0, 1'b1, 64'd0, 64'h00000000000000AA, g, r, d, e);
    ref_apply(1'b1, 64'd8, 64'h00000000000000BB, ed, ee);
    access(0, 1'b1, 64'd8, 64'h00000000000000BB, g, r, d, e);
    ref_apply(1'b0, 64'd3, '0, ed, ee);
    access(0, 1'b0, 64'd3, '0, g, r, d, e);
    vectors++;
    if (d !== 64'h0000BB0000000000 || e !== 1'b0 || ed !== 64'h0000BB0000000000) begin
      miscompares++; $display("FAIL unaligned: rdata=%h err=%b required 0000bb0000000000 0", d, e);
    end
  endtask

  task automatic test_back_to_back();
    int gc[$], rc[$]; logic [63:0] exp_d; int bad;
    exp_d = ref_read(64'd16);
    bad = 0;
    drive(0, 1'b1, 1'b0, 64'd16, '0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (a_gnt) gc.push_back(c);
      if (a_rsp_valid) begin rc.push_back(c); if (a_rdata !== exp_d) bad++; end
    end
    drive(0, 1'b0, 1'b0, 64'd16, '0);
    tick();
    last_owner_b = 1'b0;
    vectors++;
    if (rc.size() != 3 || gc.size() != 3) begin
      miscompares++; $display("FAIL b2b_count: gnts=%0d rsps=%0d required 3 3", gc.size(), rc.size());
    end else begin
      vectors++;
      if (rc[0] != 2 || rc[1] != 5 || rc[2] != 8 || gc[0] != 1 || gc[1] != 4 || gc[2] != 7) begin
        miscompares++; $display("FAIL b2b_cycles: rsp=%0d,%0d,%0d gnt=%0d,%0d,%0d required 2,5,8 1,4,7",
                                rc[0], rc[1], rc[2], gc[0], gc[1], gc[2]);
      end
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL b2b_rdata: %0d wrong, required 0", bad); end
  endtask

  task automatic test_conflict();
    int gc[$]; bit gown[$]; bit exp1, exp2;
    do_reset();
    exp1 = model_pick_b(); last_owner_b = exp1;
    exp2 = model_pick_b(); last_owner_b = exp2;
    drive(0, 1'b1, 1'b0, 64'd0, '0);
    drive(1, 1'b1, 1'b0, 64'd8, '0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (a_gnt) begin gc.push_back(c); gown.push_back(1'b0); end
      if (b_gnt) begin gc.push_back(c); gown.push_back(1'b1); end
    end
    drive(0, 1'b0, 1'b0, 64'd0, '0);
    drive(1, 1'b0, 1'b0, 64'd8, '0);
    tick();
    vectors++;
    if (gc.size() != 2) begin
      miscompares++; $display("FAIL conflict_count: gnts=%0d required 2", gc.size());
    end else begin
      vectors++;
      if (gc[0] != 1 || gc[1] != 4 || gown[0] != exp1 || gown[1] != exp2) begin
        miscompares++; $display("FAIL conflict_order: cyc=%0d,%0d own(b)=%0d,%0d required 1,4 %0d,%0d",
                                gc[0], gc[1], gown[0], gown[1], exp1, exp2);
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int it = 0; it < n; it++) begin
      bit act[2]; bit we[2]; logic [63:0] ad[2], wd[2], er[2], od[2];
      logic ee[2], oe[2]; int eg[2], og[2], orc[2]; int mode, first, need, done;
      mode = int'($urandom_range(0, 2));
      act[0] = (mode != 1); act[1] = (mode != 0);
      for (int p = 0; p < 2; p++) begin
        we[p] = 1'($urandom_range(0, 1)); ad[p] = rand_addr(); wd[p] = {$urandom, $urandom};
        og[p] = -1; orc[p] = -1; od[p] = 'x; oe[p] = 1'bx; eg[p] = -1; er[p] = '0; ee[p] = 1'b0;
      end
      if (act[0] && act[1]) first = int'(model_pick_b()); else first = act[0] ? 0 : 1;
      ref_apply(we[first], ad[first], wd[first], er[first], ee[first]);
      eg[first] = 1; last_owner_b = (first != 0); need = 1;
      if (act[0] && act[1]) begin
        ref_apply(we[1-first], ad[1-first], wd[1-first], er[1-first], ee[1-first]);
        eg[1-first] = 4; last_owner_b = (first == 0); need = 2;
      end
      for (int p = 0; p < 2; p++) drive(p, act[p], we[p], ad[p], wd[p]);
      done = 0;
      for (int c = 1; c <= 12 && done < need; c++) begin
        tick();
        for (int p = 0; p < 2; p++) begin
          if (act[p] && gnt_of(p)) begin og[p] = c; drive(p, 1'b0, we[p], ad[p], wd[p]); end
          if (act[p] && rsp_of(p)) begin orc[p] = c; od[p] = rdata_of(p); oe[p] = err_of(p); done++; end
        end
      end
      for (int p = 0; p < 2; p++) drive(p, 1'b0, we[p], ad[p], wd[p]);
      tick();
      for (int p = 0; p < 2; p++) begin
        if (act[p]) begin
          vectors++;
          if (og[p] != eg[p] || orc[p] != eg[p] + 1) begin
            miscompares++; $display("FAIL rand%0d_timing port%0d: gnt=%0d rsp=%0d required %0d %0d",
                                    it, p, og[p], orc[p], eg[p], eg[p] + 1);
          end
          vectors++;
          if (od[p] !== er[p] || oe[p] !== ee[p]) begin
            miscompares++; $display("FAIL rand%0d_data port%0d addr=%h: rdata=%h err=%b required %h %b",
                                    it, p, ad[p], od[p], oe[p], er[p], ee[p]);
          end
        end
      end
    end
  endtask

  task automatic test_final_state();
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL final_mem: %0d bytes differ, required 0", bad); end
    vectors++;
    if (violations != 0) begin miscompares++; $display("FAIL protocol: %0d violations, required 0", violations); end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_write_read();
    test_range();
    test_reset_during_write();
    test_unaligned();
    test_back_to_back();
    test_conflict();
    test_random(200);
    test_final_state();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-ported 64-byte data memory. It shares the memory between requester A (the processor load/store path) and requester B (the test loader/debug port). Each accepted request is sequenced as one 64-bit little-endian access. Out-of-range addresses are range-checked and rejected without touching memory, and read data is returned through a registered response.

## Interface
Parameters:
- MEM_BYTES, 64, size of the attached memory in bytes; valid doubleword addresses are 0..MEM_BYTES-8.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- a_req / b_req  in  1  access request; requester holds it and its fields stable until it sees gnt.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  64  byte address.
- a_wdata / b_wdata  in  64  write data.
- a_gnt / b_gnt  out  1  one-cycle pulse: request accepted.
- a_rsp_valid / b_rsp_valid  out  1  one-cycle pulse: access complete.
- a_rdata / b_rdata  out  64  read data, valid with rsp_valid; 0 for writes and errors.
- a_err / b_err  out  1  out-of-range flag, valid with rsp_valid.
- mem_addr  out  64  to memory Mem_Addr.
- mem_wdata  out  64  to memory Write_Data.
- mem_write  out  1  to memory MemWrite.
- mem_read  out  1  to memory MemRead.
- mem_rdata  in  64  from memory Read_Data (combinational).

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If any req is high, select the winner.
  - Latch its we, addr and wdata, the owner ID and an error flag.
  - The error flag is set when addr > MEM_BYTES-8, using a full 64-bit unsigned compare.
  - Go to ACCESS. Otherwise stay in IDLE.
- ACCESS:
  - Owner's gnt = 1. mem_addr = latched addr and mem_wdata = latched wdata.
  - mem_write = latched we & ~err & ~reset.
  - mem_read = ~latched we & ~err.
  - At the clock edge, capture rdata = (read & ~err) ? mem_rdata : 0. Go to RESP.
- RESP:
  - Owner's rsp_valid = 1, with rdata and err driven from registers.
  - The non-owner's rsp_valid, rdata and err stay 0. Go to IDLE.
- req is ignored outside IDLE. A requester still holding req after its RESP is treated as a new request.
- Outside ACCESS: mem_write = mem_read = 0; mem_addr and mem_wdata hold their last latched values (0 after reset).
- Arbitration (see Configuration) applies only when a_req and b_req are both high in IDLE.
- Reset values:
  - State = IDLE.
  - All gnt, rsp_valid and err = 0; all rdata = 0.
  - mem_write = 0, mem_read = 0, mem_addr = 0, mem_wdata = 0.
  - Last-owner register = B.

## Timing
- Cycle 0: IDLE samples req.
- Cycle 1: ACCESS, gnt pulse; the memory write commits at the end of this cycle.
- Cycle 2: RESP, rsp_valid pulse.
- Throughput is one access per 3 cycles. Back-to-back requests from one port give rsp_valid at cycles 2, 5, 8, …
- Reset asserted during ACCESS: mem_write is forced low, so no write occurs. The response is dropped and the state goes to IDLE at that edge.
- Reset asserted during RESP: rsp_valid is still driven in that cycle, and all outputs clear from the next cycle.
- Write followed by a read of the same address (any requester) returns the new data, because the write commits before the next ACCESS.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - On a conflict, the requester that did not own the most recent access wins.
  - The last-owner register updates on every transition IDLE→ACCESS.
  - Because reset sets last-owner = B, A wins the first conflict.
- DMEM_ARB_RR_EN undefined: fixed priority, A always beats B. The last-owner register is not implemented.

## Test plan
- **Write then read:** A writes 0x1122334455667788 to addr 8, then reads addr 8.
  - a_gnt rises in cycle 1 and a_rsp_valid in cycle 2.
  - The memory byte at address 8 becomes 0x88.
  - The read returns a_rdata = 0x1122334455667788 with a_err = 0.
- **Range check:** B requests a write to addr 57.
  - b_err = 1 and b_rdata = 0.
  - mem_write stays 0 throughout, and memory is unchanged.
  - Addr 56 is accepted with b_err = 0.
- **Conflict:** a_req and b_req rise together and stay high for 6 cycles.
  - With DMEM_ARB_RR_EN: grant order A, B.
  - Without it: A, A.
  - gnt pulses occur at cycles 1 and 4 in both cases.
- **Reset during a write:** reset is asserted in the ACCESS cycle of an A write of 0xFFFFFFFFFFFFFFFF to addr 0.
  - Memory at addr 0 stays 0.
  - No rsp_valid is produced.
  - All outputs are 0 on the following cycle.
- **Unaligned read:** A reads addr 3 after 0x00000000000000AA has been written at addr 0 and 0x00000000000000BB at addr 8.
  - a_rdata = 0x0000BB0000000000.
